// File: rtl/mt_stream_gen.sv
// mt_stream_gen: Mersenne Twister (MT19937 / MT19937-64) word stream with a
// valid/ready output, runtime reseed and automatic DEFAULT_SEED start-up.
// State lives in an N x W RAM with one write port and two combinational read
// ports. TWIST reads mt[i+1] and mt[i+M] each cycle and keeps mt[i] from the
// previous cycle's read, so the pass runs in place in N+1 cycles with strictly
// sequential semantics.
module mt_stream_gen #(
  parameter int              W            = 32,
  parameter int              N            = 624,
  parameter int              M            = 397,
  parameter int              R            = 31,
  parameter logic [W-1:0]    A            = 32'h9908B0DF,
  parameter int              U            = 11,
  parameter logic [W-1:0]    D            = 32'hFFFFFFFF,
  parameter int              S            = 7,
  parameter logic [W-1:0]    B            = 32'h9D2C5680,
  parameter int              T            = 15,
  parameter logic [W-1:0]    C            = 32'hEFC60000,
  parameter int              L            = 18,
  parameter logic [W-1:0]    F            = 32'd1812433253,
  parameter logic [W-1:0]    DEFAULT_SEED = 32'd5489,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [W-1:0]     seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] block_cnt
);

  // Index width holds 0..N so RUN can mark "all words loaded" with idx == N.
  localparam int IW = $clog2(N + 1);
  localparam logic [W-1:0] LOWMASK = {{(W-R){1'b0}}, {R{1'b1}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] WRAP_IDX = IW'(N - M);

  typedef enum logic [1:0] {S_INIT, S_TWIST, S_RUN} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx;
  logic           prime;
  logic [W-1:0]   seed_q;
  logic [W-1:0]   prev_p0;
  logic [W-1:0]   cur_p0;

  logic [W-1:0]   mem [N];
  logic [IW-1:0]  ra_addr, rb_addr, wr_addr;
  logic [W-1:0]   ra_data, rb_data, wr_data;
  logic           wr_en;

  logic [IW-1:0]  idx_inc, idx_p1, idx_pm;
  logic [W-1:0]   init_val, twist_x, twist_xa, twist_val;
  logic           xfer, end_blk, run_done, can_load;

  function automatic logic [W-1:0] temper(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x ^ ((x >> U) & D);
    y = y ^ ((y << S) & B);
    y = y ^ ((y << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  // State RAM write port; reads are combinational.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

  // Index helpers: (i+1) mod N and (i+M) mod N without any division.
  always_comb begin
    idx_inc = idx + IW'(1);
    idx_p1  = (idx == LAST_IDX) ? '0 : idx_inc;
    idx_pm  = (idx >= WRAP_IDX) ? (idx - WRAP_IDX) : (idx + IW'(M));
  end

  // Seeding recurrence and twist datapath.
  always_comb begin
    init_val  = F * (prev_p0 ^ (prev_p0 >> (W - 2))) + W'(idx);
    twist_x   = (cur_p0 & ~LOWMASK) | (ra_data & LOWMASK);
    twist_xa  = (twist_x >> 1) ^ (twist_x[0] ? A : '0);
    twist_val = rb_data ^ twist_xa;
  end

  assign xfer     = out_valid & out_ready;
  assign end_blk  = xfer & out_last;
  assign run_done = (idx == IW'(N));
  assign can_load = ~out_valid | out_ready;
  assign busy     = (state != S_RUN);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next state and RAM port control.
  always_comb begin
    state_nxt = state;
    ra_addr   = '0;
    rb_addr   = idx_pm;
    wr_en     = 1'b0;
    wr_addr   = idx;
    wr_data   = init_val;
    case (state)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_data = (idx == '0) ? seed_q : init_val;
        if (idx == LAST_IDX) state_nxt = S_TWIST;
      end
      S_TWIST: begin
        ra_addr = prime ? '0 : idx_p1;
        wr_en   = ~prime;
        wr_data = twist_val;
        if (!prime && idx == LAST_IDX) state_nxt = S_RUN;
      end
      S_RUN: begin
        ra_addr = run_done ? '0 : idx;
        if (end_blk) state_nxt = S_TWIST;
      end
      default: state_nxt = S_INIT;
    endcase
    if (seed_valid) state_nxt = S_INIT;
  end

  // Index, seed, twist registers and the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      prime     <= 1'b0;
      seed_q    <= DEFAULT_SEED;
      prev_p0   <= '0;
      cur_p0    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      block_cnt <= '0;
    end else if (seed_valid) begin
      seed_q    <= seed;
      idx       <= '0;
      prime     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      block_cnt <= '0;
    end else begin
      case (state)
        // INIT stage: one seeded word per cycle, remember it for the next.
        S_INIT: begin
          prev_p0 <= wr_data;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            prime <= 1'b1;
          end else begin
            idx <= idx_inc;
          end
        end
        // TWIST stage: the read of mt[i+1] becomes mt[i] for the next step.
        S_TWIST: begin
          cur_p0 <= ra_data;
          if (prime) begin
            prime <= 1'b0;
          end else if (idx == LAST_IDX) begin
            idx <= '0;
          end else begin
            idx <= idx_inc;
          end
        end
        // RUN stage: output register refills whenever it is empty or draining.
        S_RUN: begin
          if (end_blk) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            block_cnt <= block_cnt + 1'b1;
            idx       <= '0;
            prime     <= 1'b1;
          end else if (can_load) begin
            if (!run_done) begin
              out_data  <= temper(ra_data);
              out_last  <= (idx == LAST_IDX);
              out_valid <= 1'b1;
              idx       <= idx_inc;
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mt_stream_gen.sv
// Testbench for mt_stream_gen: a reference MT19937 kept as plain arrays checks
// every transferred 32-bit word; a W=64 instance is pinned with known values.
module tb_mt_stream_gen;

  localparam int N32 = 624;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_valid = 1'b0;
  logic [31:0] seed = '0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [15:0] block_cnt;

  logic        sv64 = 1'b0;
  logic [63:0] seed64 = '0;
  logic        rdy64 = 1'b1;
  logic        v64, last64, busy64;
  logic [63:0] d64;
  logic [15:0] cnt64;

  mt_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .block_cnt(block_cnt)
  );

  mt_stream_gen #(
    .W(64), .N(312), .M(156), .R(31), .A(64'hB5026F5AA96619E9),
    .U(29), .D(64'h5555555555555555), .S(17), .B(64'h71D67FFFEDA60000),
    .T(37), .C(64'hFFF7EEE000000000), .L(43), .F(64'd6364136223846793005),
    .DEFAULT_SEED(64'd5489), .CNT_W(16)
  ) dut64 (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv64), .seed(seed64),
    .out_valid(v64), .out_ready(rdy64), .out_data(d64),
    .out_last(last64), .busy(busy64), .block_cnt(cnt64)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Reference MT19937 written straight from the algorithm definition.
  logic [31:0] mt_m [N32];
  int          mi;

  function automatic void m_seed(input logic [31:0] s);
    mt_m[0] = s;
    for (int i = 1; i < N32; i++)
      mt_m[i] = 32'd1812433253 * (mt_m[i-1] ^ (mt_m[i-1] >> 30)) + 32'(i);
    mi = N32;
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] x, y;
    if (mi >= N32) begin
      for (int i = 0; i < N32; i++) begin
        x = (mt_m[i] & 32'h80000000) | (mt_m[(i+1) % N32] & 32'h7FFFFFFF);
        mt_m[i] = mt_m[(i+397) % N32] ^ (x >> 1) ^ (x[0] ? 32'h9908B0DF : 32'h0);
      end
      mi = 0;
    end
    y = mt_m[mi];
    mi++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  logic [15:0] m_blk = '0;
  int          n_xfer = 0;
  int          n_stall = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] cap0 = '0, cap1 = '0, cap9999 = '0;

  // Per-cycle comparison of the 32-bit stream against the reference.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    logic        exp_last;
    if (!rst_n) begin
      m_seed(32'd5489);
      m_blk = '0;
      n_xfer = 0;
      stall_prev = 1'b0;
    end else begin
      check("block_cnt", {48'd0, block_cnt}, {48'd0, m_blk});
      check("valid_while_busy", {63'd0, out_valid & busy}, 64'd0);
      if (stall_prev) begin
        check("stall_data", {32'd0, out_data}, {32'd0, prev_data});
        check("stall_last", {63'd0, out_last}, {63'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        exp_w = m_next();
        exp_last = (mi == N32);
        check("out_data", {32'd0, out_data}, {32'd0, exp_w});
        check("out_last", {63'd0, out_last}, {63'd0, exp_last});
        if (n_xfer == 0) cap0 = out_data;
        if (n_xfer == 1) cap1 = out_data;
        if (n_xfer == 9999) cap9999 = out_data;
        n_xfer++;
        if (exp_last) m_blk = m_blk + 16'd1;
      end
      if (out_valid && !out_ready) n_stall++;
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (seed_valid) begin
        m_seed(seed);
        m_blk = '0;
        n_xfer = 0;
        stall_prev = 1'b0;
      end
    end
  end

  int          c64 = 0;
  logic [63:0] cap64_0 = '0, cap64_9999 = '0;

  // W=64 instance: capture known positions, check out_last every 312th word.
  always @(negedge clk) begin
    if (!rst_n) begin
      c64 = 0;
    end else if (v64) begin
      if (c64 == 0) cap64_0 = d64;
      if (c64 == 9999) cap64_9999 = d64;
      check("out_last_64", {63'd0, last64}, {63'd0, ((c64 % 312) == 311)});
      c64++;
    end
  end

  logic rnd_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic reseed(input logic [31:0] s);
    seed = s;
    seed_valid = 1'b1;
    step();
    seed_valid = 1'b0;
  endtask

  initial begin
    int t, nb, nv, tw;

    // Reset state
    repeat (3) step();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", {32'd0, out_data}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_cnt", {48'd0, block_cnt}, 64'd0);
    check("rst_busy64", {63'd0, busy64}, 64'd1);
    check("rst_cnt64", {48'd0, cnt64}, 64'd0);
    rst_n = 1'b1;

    // Default streams, always ready, 10000 words on both widths
    t = 0;
    while ((n_xfer < 10000 || c64 < 10000) && t < 60000) begin step(); t++; end
    check("t1_timeout", {63'd0, (n_xfer >= 10000 && c64 >= 10000)}, 64'd1);
    check("t1_word0", {32'd0, cap0}, 64'd3499211612);
    check("t1_word1", {32'd0, cap1}, 64'd581869302);
    check("t1_word9999", {32'd0, cap9999}, 64'd4123659995);
    check("t2_word0", cap64_0, 64'd14514284786278117030);
    check("t2_word9999", cap64_9999, 64'd9981545732273789042);

    // Random backpressure over three blocks from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rnd_ready = 1'b1;
    t = 0;
    while (block_cnt != 16'd3 && t < 30000) begin step(); t++; end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    check("t3_blocks", {48'd0, block_cnt}, 64'd3);
    check("t3_word0", {32'd0, cap0}, 64'd3499211612);
    check("t3_stalls_seen", {63'd0, (n_stall > 0)}, 64'd1);

    // Reseed with 1 mid-block
    t = 0;
    while (busy && t < 3000) begin step(); t++; end
    repeat (50) step();
    reseed(32'd1);
    check("t4a_cnt", {48'd0, block_cnt}, 64'd0);
    check("t4a_valid", {63'd0, out_valid}, 64'd0);
    t = 0;
    while (n_xfer < 2 && t < 3000) begin step(); t++; end
    check("t4a_word0", {32'd0, cap0}, 64'd1791095845);
    check("t4a_word1", {32'd0, cap1}, 64'd4282876139);

    // Reseed with 1 again after two blocks
    t = 0;
    while (block_cnt != 16'd2 && t < 6000) begin step(); t++; end
    check("t4b_two_blocks", {48'd0, block_cnt}, 64'd2);
    repeat (10) step();
    reseed(32'd1);
    check("t4b_cnt", {48'd0, block_cnt}, 64'd0);
    t = 0;
    while (n_xfer < 2 && t < 3000) begin step(); t++; end
    check("t4b_word0", {32'd0, cap0}, 64'd1791095845);
    check("t4b_word1", {32'd0, cap1}, 64'd4282876139);

    // Reseed on the same cycle as the out_last transfer
    t = 0;
    while (!(out_valid && out_last) && t < 4000) begin step(); t++; end
    check("t6_found_last", {63'd0, (out_valid && out_last)}, 64'd1);
    reseed(32'hCAFEF00D);
    check("t6_cnt", {48'd0, block_cnt}, 64'd0);
    check("t6_valid", {63'd0, out_valid}, 64'd0);
    check("t6_no_extra", n_xfer, 64'd0);
    t = 0;
    while (n_xfer < 3 && t < 3000) begin step(); t++; end
    check("t6_new_stream", {63'd0, (n_xfer >= 3)}, 64'd1);

    // Asynchronous reset in the middle of TWIST
    t = 0;
    while (block_cnt != 16'd1 && t < 4000) begin step(); t++; end
    repeat (40) step();
    check("t5_in_twist", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_valid", {63'd0, out_valid}, 64'd0);
    check("t5_data", {32'd0, out_data}, 64'd0);
    check("t5_last", {63'd0, out_last}, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd1);
    check("t5_cnt", {48'd0, block_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nb = 0;
    while (busy && nb < 5000) begin step(); nb++; end
    check("t5_init_twist_len", {63'd0, (nb >= N32 && nb <= 3 * N32 + 8)}, 64'd1);
    nv = 0;
    while (!out_valid && nv < 10) begin step(); nv++; end
    check("t5_valid_latency", {63'd0, (nv <= 3)}, 64'd1);
    t = 0;
    while (n_xfer < 1 && t < 100) begin step(); t++; end
    check("t5_word0", {32'd0, cap0}, 64'd3499211612);
    t = 0;
    while (!busy && t < 3000) begin step(); t++; end
    tw = 0;
    while (busy && tw < 5000) begin step(); tw++; end
    check("t5_twist_len", {63'd0, (tw <= 2 * N32 + 8)}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
